// File: rtl/maj_chain_pkg.sv
// Shared helpers for the MAJ3 chain pipeline: lane-wise majority and stage/skew geometry.
package maj_chain_pkg;

  localparam int MAJ_MAX_W = 64;

  function automatic logic [MAJ_MAX_W-1:0] maj3(input logic [MAJ_MAX_W-1:0] a,
                                                input logic [MAJ_MAX_W-1:0] b,
                                                input logic [MAJ_MAX_W-1:0] c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Number of registered chain segments after the leaf register.
  function automatic int n_stages(input int n_grp, input int reg_every);
    return (n_grp - 2 + reg_every - 1) / reg_every;
  endfunction

  function automatic int lat(input int n_grp, input int reg_every);
    return 1 + n_stages(n_grp, reg_every);
  endfunction

  // Chain steps already folded into acc at the output of stage s (stage 0 holds acc = w[0]).
  function automatic int steps_done(input int s, input int n_grp, input int reg_every);
    int t;
    t = s * reg_every;
    return (t > n_grp - 2) ? n_grp - 2 : t;
  endfunction

  // w[] values still needed after t steps: w[t+1 .. n_grp-1], none once the chain is done.
  function automatic int skew_n(input int t, input int n_grp);
    return (t >= n_grp - 2) ? 0 : n_grp - 1 - t;
  endfunction

endpackage

// File: rtl/maj_chain_stage.sv
// One pipeline slice of the MAJ3 chain: valid, running acc and the skewed w[] still to be consumed.
module maj_chain_stage #(
  parameter int W    = 1,
  parameter int SK_N = 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              adv,
  input  logic                              d_valid,
  input  logic [W-1:0]                      d_acc,
  input  logic [(SK_N > 0 ? SK_N : 1)*W-1:0] d_skew,
  output logic                              q_valid,
  output logic [W-1:0]                      q_acc,
  output logic [(SK_N > 0 ? SK_N : 1)*W-1:0] q_skew
);

  // Data only moves on a real beat so holes leave the previous contents in place.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_valid <= 1'b0;
      q_acc   <= '0;
      q_skew  <= '0;
    end else if (adv) begin
      q_valid <= d_valid;
      if (d_valid) begin
        q_acc  <= d_acc;
        q_skew <= d_skew;
      end
    end
  end

endmodule

// File: rtl/maj_chain_pipe.sv
// Pipelined MAJ3-chain evaluator with valid/ready streaming and a global stall.
// Optional per-operand complement input in_pol is enabled by defining MAJ_CHAIN_POL_EN.
module maj_chain_pipe
  import maj_chain_pkg::*;
#(
  parameter int N_GRP     = 6,
  parameter int W         = 1,
  parameter int REG_EVERY = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3*N_GRP*W-1:0] in_data,
`ifdef MAJ_CHAIN_POL_EN
  input  logic [3*N_GRP-1:0]   in_pol,
`endif
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [W-1:0]         out_data
);

  localparam int NS = n_stages(N_GRP, REG_EVERY);

  if (N_GRP < 3 || W < 1 || REG_EVERY < 1 || W > MAJ_MAX_W) begin : g_param_err
    $error("maj_chain_pipe: illegal parameters N_GRP=%0d W=%0d REG_EVERY=%0d",
           N_GRP, W, REG_EVERY);
  end

  logic                 adv;
  logic [3*N_GRP*W-1:0] opnd;
  logic [N_GRP*W-1:0]   w_leaf;

`ifdef MAJ_CHAIN_POL_EN
  always_comb begin
    opnd = '0;
    for (int i = 0; i < 3*N_GRP; i++)
      opnd[i*W +: W] = in_data[i*W +: W] ^ {W{in_pol[i]}};
  end
`else
  assign opnd = in_data;
`endif

  always_comb begin
    w_leaf = '0;
    for (int k = 0; k < N_GRP; k++)
      w_leaf[k*W +: W] = W'(maj3(MAJ_MAX_W'(opnd[(3*k)*W   +: W]),
                                 MAJ_MAX_W'(opnd[(3*k+1)*W +: W]),
                                 MAJ_MAX_W'(opnd[(3*k+2)*W +: W])));
  end

  for (genvar s = 0; s <= NS; s++) begin : g_st
    localparam int T   = steps_done(s, N_GRP, REG_EVERY);
    localparam int SKN = skew_n(T, N_GRP);
    localparam int SKW = (SKN > 0 ? SKN : 1) * W;

    logic           d_valid;
    logic [W-1:0]   d_acc;
    logic [SKW-1:0] d_skew;
    logic           q_valid;
    logic [W-1:0]   q_acc;
    logic [SKW-1:0] q_skew;

    if (s == 0) begin : g_leaf
      assign d_valid = in_valid;
      assign d_acc   = w_leaf[0 +: W];
      assign d_skew  = w_leaf[W +: (N_GRP-1)*W];
    end else begin : g_seg
      localparam int T0 = steps_done(s - 1, N_GRP, REG_EVERY);
      // Previous skew holds w[T0+1 ..], so w[i+1] sits at slot i-T0.
      always_comb begin
        d_acc = g_st[s-1].q_acc;
        for (int i = T0; i < T; i++)
          d_acc = W'(maj3(MAJ_MAX_W'(d_acc),
                          MAJ_MAX_W'(g_st[s-1].q_skew[(i-T0)*W   +: W]),
                          MAJ_MAX_W'(g_st[s-1].q_skew[(i-T0+1)*W +: W])));
      end
      assign d_valid = g_st[s-1].q_valid;
      if (SKN > 0) begin : g_fwd
        assign d_skew = g_st[s-1].q_skew[(T-T0)*W +: SKW];
      end else begin : g_done
        assign d_skew = '0;
      end
    end

    maj_chain_stage #(.W(W), .SK_N(SKN)) u_stage (
      .clk    (clk),
      .rst_n  (rst_n),
      .adv    (adv),
      .d_valid(d_valid),
      .d_acc  (d_acc),
      .d_skew (d_skew),
      .q_valid(q_valid),
      .q_acc  (q_acc),
      .q_skew (q_skew)
    );
  end

  // Whole pipe shifts together; a stalled output freezes every stage.
  assign adv       = ~out_valid | out_ready;
  assign in_ready  = adv;
  assign out_valid = g_st[NS].q_valid;
  assign out_data  = g_st[NS].q_acc;

endmodule
